// File: rtl/codec_reg_arbiter_pkg.sv
// Shared types and constants for the codec register-access path.
// Register addresses are also used by the codec init unit.
package codec_pkg;

    localparam int CODEC_ADDR_W = 9;
    localparam int CODEC_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        COMPLETE,
        RELEASE
    } arb_state_t;

    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_LLINE_IN  = 9'h000;
    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_RLINE_IN  = 9'h001;
    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_LHP_OUT   = 9'h002;
    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_RHP_OUT   = 9'h003;
    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_ANA_PATH  = 9'h004;
    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_DIG_PATH  = 9'h005;
    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_PWR_DOWN  = 9'h006;
    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_DIG_IF    = 9'h007;
    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_SAMPLING  = 9'h008;
    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_ACTIVE    = 9'h009;
    localparam logic [CODEC_ADDR_W-1:0] CODEC_REG_RESET     = 9'h00F;

    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/codec_reg_arbiter_if.sv
// Register-access port between the arbiter (master) and the I2C controller (slave).
interface codec_reg_arbiter_if;
    import codec_pkg::*;

    logic                    codec_rd_en;
    logic                    codec_wr_en;
    logic [CODEC_ADDR_W-1:0] codec_reg_addr;
    logic [CODEC_DATA_W-1:0] codec_data_out;
    logic [CODEC_DATA_W-1:0] codec_data_in;
    logic                    codec_data_in_valid;
    logic                    controller_busy;

    modport master (
        output codec_rd_en, codec_wr_en, codec_reg_addr, codec_data_out,
        input  codec_data_in, codec_data_in_valid, controller_busy
    );

    modport slave (
        input  codec_rd_en, codec_wr_en, codec_reg_addr, codec_data_out,
        output codec_data_in, codec_data_in_valid, controller_busy
    );

endinterface

// File: rtl/codec_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module codec_rr_arbiter
    import codec_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [idx_w(NUM_REQ)-1:0]   ptr,
    output logic [idx_w(NUM_REQ)-1:0]   grant,
    output logic                        any_req
);

    localparam int IDX_W = idx_w(NUM_REQ);

    // Walk from the farthest offset down so the nearest request wins.
    always_comb begin
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_REQ]) begin
                grant = IDX_W'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/codec_reg_arbiter.sv
// Shares the codec register port of the I2C controller between NUM_REQ requesters.
// state     | meaning
// IDLE      | waiting for an eligible request
// ISSUE     | one-cycle rd/wr strobe to the controller
// WAIT_BUSY | waiting for controller_busy to rise
// WAIT_DONE | waiting for read data or busy to fall
// COMPLETE  | result settled; done pulse launched, pointer advanced
// RELEASE   | requests ignored while the finished requester drops its request
module codec_reg_arbiter
    import codec_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int BUSY_WAIT      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           init_lock,
    input  logic [NUM_REQ-1:0]             req_rd,
    input  logic [NUM_REQ-1:0]             req_wr,
    input  logic [CODEC_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [CODEC_DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             req_done,
    output logic                           req_error,
    output logic [CODEC_DATA_W-1:0]        req_rdata,
    output logic [idx_w(NUM_REQ)-1:0]      grant_id,
    output logic                           arb_busy,
    codec_reg_arbiter_if.master            bus
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = $clog2(max_int(BUSY_WAIT, TIMEOUT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_WAIT - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t              state, state_n;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        ptr, pick;
    logic [NUM_REQ-1:0]      lock_mask, eligible;
    logic                    any_req, op_rd, err_q, err_n, cap_en, rd_en_n, wr_en_n;
    logic [CODEC_DATA_W-1:0] cap_q;

    assign lock_mask = init_lock ? NUM_REQ'(1) : {NUM_REQ{1'b1}};
    assign eligible  = (req_rd | req_wr) & lock_mask;

    codec_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (eligible),
        .ptr     (ptr),
        .grant   (pick),
        .any_req (any_req)
    );

    always_comb begin
        state_n = state;
        err_n   = err_q;
        cap_en  = 1'b0;
        rd_en_n = 1'b0;
        wr_en_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    if (req_rd[pick] && req_wr[pick]) begin
                        state_n = COMPLETE;
                        err_n   = 1'b1;
                    end else begin
                        state_n = ISSUE;
                        err_n   = 1'b0;
                        rd_en_n = req_rd[pick];
                        wr_en_n = req_wr[pick];
                    end
                end
            end
            ISSUE: state_n = WAIT_BUSY;
            WAIT_BUSY: begin
                // A fast controller may return read data before busy is ever seen.
                if (op_rd && bus.codec_data_in_valid) begin
                    cap_en  = 1'b1;
                    state_n = COMPLETE;
                end else if (bus.controller_busy) begin
                    state_n = WAIT_DONE;
                end else if (cnt == BUSY_LAST) begin
                    err_n   = 1'b1;
                    state_n = COMPLETE;
                end
            end
            WAIT_DONE: begin
                if (op_rd && bus.codec_data_in_valid) begin
                    cap_en  = 1'b1;
                    state_n = COMPLETE;
                end else if (!bus.controller_busy) begin
                    err_n   = op_rd;
                    state_n = COMPLETE;
                end else if (cnt == TMO_LAST) begin
                    err_n   = 1'b1;
                    state_n = COMPLETE;
                end
            end
            COMPLETE: state_n = RELEASE;
            RELEASE:  state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            ptr                <= '0;
            op_rd              <= 1'b0;
            err_q              <= 1'b0;
            cap_q              <= '0;
            grant_id           <= '0;
            arb_busy           <= 1'b0;
            req_done           <= '0;
            req_error          <= 1'b0;
            req_rdata          <= '0;
            bus.codec_rd_en    <= 1'b0;
            bus.codec_wr_en    <= 1'b0;
            bus.codec_reg_addr <= '0;
            bus.codec_data_out <= '0;
        end else begin
            state           <= state_n;
            cnt             <= (state_n != state || state == IDLE) ? '0 : cnt + CNT_W'(1);
            err_q           <= err_n;
            arb_busy        <= (state_n != IDLE);
            bus.codec_rd_en <= rd_en_n;
            bus.codec_wr_en <= wr_en_n;
            if (state == IDLE && any_req) begin
                grant_id           <= pick;
                op_rd              <= req_rd[pick];
                bus.codec_reg_addr <= req_addr[int'(pick)*CODEC_ADDR_W +: CODEC_ADDR_W];
                bus.codec_data_out <= req_wdata[int'(pick)*CODEC_DATA_W +: CODEC_DATA_W];
            end
            if (cap_en) begin
                cap_q <= bus.codec_data_in;
            end
            req_done  <= '0;
            req_error <= 1'b0;
            if (state == COMPLETE) begin
                req_done  <= NUM_REQ'(1) << grant_id;
                req_error <= err_q;
                ptr       <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + IDX_W'(1);
                if (op_rd && !err_q) begin
                    req_rdata <= cap_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_codec_reg_arbiter.sv
// Scoreboard bench for codec_reg_arbiter: directed transactions with a scripted controller.
module tb_codec_reg_arbiter;
    import codec_pkg::*;

    localparam int NUM_REQ        = 2;
    localparam int BUSY_WAIT      = 16;
    localparam int TIMEOUT_CYCLES = 65535;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init_lock = 1'b0;
    logic [1:0]  req_rd, req_wr;
    logic [17:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_done;
    logic        req_error;
    logic [7:0]  req_rdata;
    logic [0:0]  grant_id;
    logic        arb_busy;

    codec_reg_arbiter_if bus();

    codec_reg_arbiter #(
        .NUM_REQ(NUM_REQ), .BUSY_WAIT(BUSY_WAIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .init_lock(init_lock),
        .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .req_error(req_error), .req_rdata(req_rdata),
        .grant_id(grant_id), .arb_busy(arb_busy), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] done;
        logic       err;
        logic       chk_rd;
        logic [7:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;
    int busy_fall_cyc = 0;
    int ctl_mode = 0;
    int ctl_len = 0;
    logic [7:0] ctl_data = 8'h00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Monitor: scoreboard pops on every done pulse; strobes must start from idle.
    initial begin
        exp_t e;
        logic prev_busy, prev_strobe;
        prev_busy = 1'b0;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
                prev_strobe = 1'b0;
            end else begin
                if (bus.codec_rd_en || bus.codec_wr_en) begin
                    strobe_cnt++;
                    check("strobe_from_idle", {30'd0, prev_busy, prev_strobe}, 32'd0);
                end
                if (req_done != 2'b00) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", {30'd0, req_done}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_vector", {30'd0, req_done}, {30'd0, e.done});
                        check("done_error", {31'd0, req_error}, {31'd0, e.err});
                        if (e.chk_rd) check("read_data", {24'd0, req_rdata}, {24'd0, e.rdata});
                    end
                end
                prev_busy = arb_busy;
                prev_strobe = bus.codec_rd_en | bus.codec_wr_en;
            end
        end
    end

    // Scripted I2C controller, reacting to each strobe according to ctl_mode.
    initial begin
        bus.controller_busy = 1'b0;
        bus.codec_data_in_valid = 1'b0;
        bus.codec_data_in = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset && (bus.codec_rd_en || bus.codec_wr_en)) begin
                @(posedge clk); #1;
                case (ctl_mode)
                    0, 3: begin
                        bus.controller_busy = 1'b1;
                        repeat (ctl_len) begin @(posedge clk); #1; end
                        bus.controller_busy = 1'b0;
                        busy_fall_cyc = cyc;
                    end
                    1: begin
                        bus.controller_busy = 1'b1;
                        repeat (ctl_len - 1) begin @(posedge clk); #1; end
                        bus.codec_data_in_valid = 1'b1;
                        bus.codec_data_in = ctl_data;
                        @(posedge clk); #1;
                        bus.codec_data_in_valid = 1'b0;
                        bus.controller_busy = 1'b0;
                    end
                    4: bus.controller_busy = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected bench completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_exp(input int id, input bit err, input bit chk_rd, input logic [7:0] rdata);
        exp_t e;
        e.done = (id == 1) ? 2'b10 : 2'b01;
        e.err = err;
        e.chk_rd = chk_rd;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic raise(input int id, input bit rd, input bit wr, input logic [8:0] addr, input logic [7:0] wd);
        req_addr[id*9 +: 9] = addr;
        req_wdata[id*8 +: 8] = wd;
        req_rd[id] = rd;
        req_wr[id] = wr;
    endtask

    task automatic start_req(input int id, input bit rd, input bit wr, input logic [8:0] addr,
                             input logic [7:0] wd, input bit err, input bit chk_rd, input logic [7:0] rdata);
        push_exp(id, err, chk_rd, rdata);
        raise(id, rd, wr, addr, wd);
    endtask

    task automatic wait_strobe(output int t);
        int n = 0;
        forever begin
            @(negedge clk);
            if (bus.codec_rd_en || bus.codec_wr_en || n >= 50) break;
            n++;
        end
        t = cyc;
        check("strobe_seen", {31'd0, bus.codec_rd_en | bus.codec_wr_en}, 32'd1);
    endtask

    task automatic wait_any_done(output int t);
        int n = 0;
        forever begin
            @(negedge clk);
            if (req_done != 2'b00 || n >= 300) break;
            n++;
        end
        t = cyc;
        check("done_seen", {31'd0, req_done != 2'b00}, 32'd1);
    endtask

    task automatic finish_req(input int id, output int t);
        int n = 0;
        forever begin
            @(negedge clk);
            if (req_done[id] || n >= 300) break;
            n++;
        end
        t = cyc;
        check("done_seen", {31'd0, req_done[id]}, 32'd1);
        @(posedge clk); #1;
        req_rd[id] = 1'b0;
        req_wr[id] = 1'b0;
    endtask

    initial begin
        int t0, ts, td, s0, d0, id;
        req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        step(3);
        @(negedge clk);
        check("reset_outputs", {req_done, req_error, req_rdata, grant_id, arb_busy,
              bus.codec_rd_en, bus.codec_wr_en, bus.codec_reg_addr, bus.codec_data_out}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(2);

        // Requester 0 write, controller busy for 20 cycles
        ctl_mode = 0; ctl_len = 20;
        start_req(0, 1'b0, 1'b1, CODEC_REG_PWR_DOWN, 8'h10, 1'b0, 1'b0, 8'h00);
        t0 = cyc;
        wait_strobe(ts);
        check("t1_strobe_latency", ts - t0, 32'd1);
        check("t1_wr_en", {31'd0, bus.codec_wr_en}, 32'd1);
        check("t1_rd_en", {31'd0, bus.codec_rd_en}, 32'd0);
        check("t1_addr", {23'd0, bus.codec_reg_addr}, 32'h006);
        check("t1_wdata", {24'd0, bus.codec_data_out}, 32'h10);
        @(negedge clk);
        check("t1_strobe_width", {31'd0, bus.codec_wr_en}, 32'd0);
        finish_req(0, td);
        check("t1_done_latency", td - busy_fall_cyc, 32'd2);
        check("t1_addr_hold", {23'd0, bus.codec_reg_addr}, 32'h006);
        step(2);

        // Requester 1 read returning 0x97
        ctl_mode = 1; ctl_len = 3; ctl_data = 8'h97;
        start_req(1, 1'b1, 1'b0, CODEC_REG_LLINE_IN, 8'h00, 1'b0, 1'b1, 8'h97);
        finish_req(1, td);
        check("t2_grant_id", {31'd0, grant_id}, 32'd1);
        step(2);

        // Both requesters continuously: round-robin 0,1,0,1
        ctl_mode = 0; ctl_len = 3;
        for (int k = 0; k < 4; k++) push_exp(k % 2, 1'b0, 1'b0, 8'h00);
        raise(0, 1'b0, 1'b1, CODEC_REG_LHP_OUT, 8'h79);
        raise(1, 1'b0, 1'b1, CODEC_REG_RHP_OUT, 8'h7A);
        for (int k = 0; k < 4; k++) begin
            wait_any_done(td);
            id = req_done[1] ? 1 : 0;
            check("t3_grant_id", {31'd0, grant_id}, k % 2);
            @(posedge clk); #1;
            req_wr[id] = 1'b0;
            if (k < 2) begin
                @(posedge clk); #1;
                req_wr[id] = 1'b1;
            end
        end
        step(2);

        // init_lock blocks requester 1 until released
        init_lock = 1'b1;
        s0 = strobe_cnt;
        start_req(1, 1'b0, 1'b1, CODEC_REG_ACTIVE, 8'h01, 1'b0, 1'b0, 8'h00);
        step(10);
        @(negedge clk);
        check("t4_lock_idle", {31'd0, arb_busy}, 32'd0);
        check("t4_lock_no_strobe", strobe_cnt - s0, 32'd0);
        @(posedge clk); #1;
        init_lock = 1'b0;
        finish_req(1, td);
        check("t4_grant_id", {31'd0, grant_id}, 32'd1);
        step(2);

        // Busy never rises: BUSY_WAIT cycles of waiting after the strobe, then COMPLETE, then done
        ctl_mode = 2;
        start_req(0, 1'b0, 1'b1, CODEC_REG_ANA_PATH, 8'h7A, 1'b1, 1'b0, 8'h00);
        wait_strobe(ts);
        finish_req(0, td);
        check("t5_busy_timeout", td - ts, BUSY_WAIT + 2);
        step(2);

        // Read where busy falls without data valid
        ctl_mode = 3; ctl_len = 4;
        start_req(1, 1'b1, 1'b0, CODEC_REG_ACTIVE, 8'h00, 1'b1, 1'b0, 8'h00);
        finish_req(1, td);
        step(2);

        // Read and write together: error, no strobe
        s0 = strobe_cnt;
        start_req(0, 1'b1, 1'b1, CODEC_REG_LHP_OUT, 8'h55, 1'b1, 1'b0, 8'h00);
        finish_req(0, td);
        check("t5_rdwr_no_strobe", strobe_cnt - s0, 32'd0);
        step(2);

        // Reset in WAIT_DONE abandons the transaction
        ctl_mode = 4;
        raise(0, 1'b0, 1'b1, CODEC_REG_SAMPLING, 8'h33);
        wait_strobe(ts);
        step(5);
        check("t6_in_flight", {31'd0, arb_busy}, 32'd1);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check("t6_reset_outputs", {req_done, req_error, req_rdata, grant_id, arb_busy,
              bus.codec_rd_en, bus.codec_wr_en, bus.codec_reg_addr, bus.codec_data_out}, 32'd0);
        req_rd = '0; req_wr = '0;
        bus.controller_busy = 1'b0;
        step(2);
        reset = 1'b0;
        step(6);
        check("t6_no_done", done_cnt - d0, 32'd0);
        ctl_mode = 1; ctl_len = 2; ctl_data = 8'h55;
        start_req(1, 1'b1, 1'b0, CODEC_REG_LLINE_IN, 8'h00, 1'b0, 1'b1, 8'h55);
        finish_req(1, td);
        step(5);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
